// File: rtl/fixed_rcp_pipe.sv
// Pipelined fixed-point reciprocal / reciprocal-square-root unit.
// Table seed on the leading-one position, then Newton-Raphson refinement of 1/sqrt(|x|).
module fixed_rcp_pipe #(
    parameter int WIDTH        = 32,
    parameter int FRAC_BITS    = 14,
    parameter int NEWTON_ITERS = 3,
    parameter int TAG_W        = 8
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_mode,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic [1:0]       out_flags
);

    localparam int PW = $clog2(WIDTH);
    localparam int NS = NEWTON_ITERS + 1;
    localparam logic signed [WIDTH-1:0]   MAX_POS      = {1'b0, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   MIN_NEG      = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic signed [2*WIDTH-1:0] MAX_POS_W    = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
    localparam logic signed [WIDTH-1:0]   THREE_HALVES = WIDTH'(3 * (2 ** (FRAC_BITS - 1)));

    // Seed for a leading one at bit p: assumes the mantissa sits mid-octave (1.5).
    function automatic logic signed [WIDTH-1:0] guess_val(input int p);
        real r;
        real lim;
        r   = (2.0 ** (real'(FRAC_BITS) + (real'(FRAC_BITS) - real'(p)) / 2.0)) / $sqrt(1.5);
        lim = 2.0 ** real'(WIDTH - 2);
        if (r > lim) begin
            r = lim;
        end
        return WIDTH'(longint'(r));
    endfunction

    function automatic logic signed [WIDTH-1:0] fx_mul(
        input logic signed [WIDTH-1:0] a,
        input logic signed [WIDTH-1:0] b,
        input int                      sh
    );
        logic signed [2*WIDTH-1:0] prod;
        prod = {{WIDTH{a[WIDTH-1]}}, a} * {{WIDTH{b[WIDTH-1]}}, b};
        prod = prod >>> sh;
        return prod[WIDTH-1:0];
    endfunction

    logic signed [WIDTH-1:0] guess_tab [WIDTH];

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_seed
            localparam logic signed [WIDTH-1:0] GUESS = guess_val(gi);
            assign guess_tab[gi] = GUESS;
        end
    endgenerate

    logic                    ready_q;
    logic                    out_valid_q;
    logic [WIDTH-1:0]        out_data_q;
    logic [TAG_W-1:0]        out_tag_q;
    logic [1:0]              out_flags_q;

    logic [NS-1:0]           st_valid_q, st_valid_d;
    logic [NS-1:0]           st_mode_q,  st_mode_d;
    logic [NS-1:0]           st_neg_q,   st_neg_d;
    logic [NS-1:0]           st_zero_q,  st_zero_d;
    logic [TAG_W-1:0]        st_tag_q [NS];
    logic [TAG_W-1:0]        st_tag_d [NS];
    logic signed [WIDTH-1:0] st_ax_q  [NS];
    logic signed [WIDTH-1:0] st_ax_d  [NS];
    logic signed [WIDTH-1:0] st_y_q   [NS];
    logic signed [WIDTH-1:0] st_y_d   [NS];

    logic                    advance;
    logic                    accept;

    assign advance   = !out_valid_q || out_ready;
    assign in_ready  = ready_q && advance;
    assign accept    = in_valid && in_ready;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_tag   = out_tag_q;
    assign out_flags = out_flags_q;

    logic signed [WIDTH-1:0] x_s;
    logic [WIDTH-1:0]        abs_x;
    logic [PW-1:0]           lead_pos;

    always_comb begin
        x_s = in_data;
        if (x_s == MIN_NEG) begin
            abs_x = MAX_POS;
        end else if (x_s < 0) begin
            abs_x = -x_s;
        end else begin
            abs_x = x_s;
        end
        lead_pos = '0;
        for (int i = 0; i < WIDTH; i++) begin
            if (abs_x[i]) begin
                lead_pos = PW'(i);
            end
        end
    end

    // Newton step evaluated as ((|x|*y)*y)/2 to keep precision when y^2 is small.
    logic signed [WIDTH-1:0] nr_xy;
    logic signed [WIDTH-1:0] nr_t;
    logic signed [WIDTH-1:0] nr_e;

    always_comb begin
        nr_xy = '0;
        nr_t  = '0;
        nr_e  = '0;
        st_valid_d[0] = accept;
        st_mode_d[0]  = in_mode;
        st_neg_d[0]   = in_data[WIDTH-1];
        st_zero_d[0]  = (in_data == '0);
        st_tag_d[0]   = in_tag;
        st_ax_d[0]    = abs_x;
        st_y_d[0]     = guess_tab[lead_pos];
        for (int i = 1; i < NS; i++) begin
            nr_xy = fx_mul(st_ax_q[i-1], st_y_q[i-1], FRAC_BITS);
            nr_t  = fx_mul(nr_xy, st_y_q[i-1], FRAC_BITS + 1);
            nr_e  = THREE_HALVES - nr_t;
            st_valid_d[i] = st_valid_q[i-1];
            st_mode_d[i]  = st_mode_q[i-1];
            st_neg_d[i]   = st_neg_q[i-1];
            st_zero_d[i]  = st_zero_q[i-1];
            st_tag_d[i]   = st_tag_q[i-1];
            st_ax_d[i]    = st_ax_q[i-1];
            st_y_d[i]     = fx_mul(st_y_q[i-1], nr_e, FRAC_BITS);
        end
    end

    logic signed [WIDTH-1:0]   y_last;
    logic signed [2*WIDTH-1:0] sq_full;
    logic signed [WIDTH-1:0]   sq_sat;
    logic [WIDTH-1:0]          fin_data;
    logic [1:0]                fin_flags;

    always_comb begin
        y_last  = st_y_q[NS-1];
        sq_full = {{WIDTH{y_last[WIDTH-1]}}, y_last} * {{WIDTH{y_last[WIDTH-1]}}, y_last};
        sq_full = sq_full >>> FRAC_BITS;
        if (sq_full > MAX_POS_W) begin
            sq_sat = MAX_POS;
        end else begin
            sq_sat = sq_full[WIDTH-1:0];
        end
        fin_flags = 2'b00;
        fin_data  = sq_sat;
        if (st_zero_q[NS-1]) begin
            fin_data  = MAX_POS;
            fin_flags = 2'b01;
        end else if (st_mode_q[NS-1]) begin
            if (st_neg_q[NS-1]) begin
                fin_data  = '0;
                fin_flags = 2'b10;
            end else begin
                fin_data = y_last;
            end
        end else if (st_neg_q[NS-1]) begin
            fin_data = -sq_sat;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ready_q     <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_tag_q   <= '0;
            out_flags_q <= '0;
            st_valid_q  <= '0;
            st_mode_q   <= '0;
            st_neg_q    <= '0;
            st_zero_q   <= '0;
            for (int i = 0; i < NS; i++) begin
                st_tag_q[i] <= '0;
                st_ax_q[i]  <= '0;
                st_y_q[i]   <= '0;
            end
        end else begin
            ready_q <= 1'b1;
            if (advance) begin
                st_valid_q  <= st_valid_d;
                st_mode_q   <= st_mode_d;
                st_neg_q    <= st_neg_d;
                st_zero_q   <= st_zero_d;
                for (int i = 0; i < NS; i++) begin
                    st_tag_q[i] <= st_tag_d[i];
                    st_ax_q[i]  <= st_ax_d[i];
                    st_y_q[i]   <= st_y_d[i];
                end
                out_valid_q <= st_valid_q[NS-1];
                out_data_q  <= fin_data;
                out_tag_q   <= st_tag_q[NS-1];
                out_flags_q <= fin_flags;
            end
        end
    end

endmodule
